// File: rtl/mem_pkg.sv
// mem_pkg: shared word width, latency limits and the response record used by the memory responder
//   WORD_W              data word width
//   MEM_LATENCY_DEFAULT default read latency in cycles
//   MEM_LATENCY_MAX     largest legal read latency
//   mem_resp_t          {valid, data} record carried through the read delay line
package mem_pkg;
   localparam int WORD_W = 16;
   localparam int MEM_LATENCY_DEFAULT = 4;
   localparam int MEM_LATENCY_MAX = 8;
   typedef struct packed {
      logic              valid;
      logic [WORD_W-1:0] data;
   } mem_resp_t;
endpackage

// File: rtl/mem_valid_pipe.sv
// mem_valid_pipe: LATENCY-deep shift register of read responses with synchronous clear
//   clk    rising-edge clock
//   rst    synchronous active-high clear of every stage
//   issue  response entering the line this cycle (valid = 0 is a bubble)
//   resp   response leaving the last stage
module mem_valid_pipe
   import mem_pkg::*;
#(
   parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
   input  logic      clk,
   input  logic      rst,
   input  mem_resp_t issue,
   output mem_resp_t resp
);
   mem_resp_t stage [LATENCY];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= issue;
         for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
   end
   assign resp = stage[LATENCY-1];
endmodule

// File: rtl/multicycle_mem.sv
// multicycle_mem: word-addressed 16-bit memory returning each read exactly LATENCY cycles after issue
//   clk, rst    clock and synchronous active-high reset (array contents survive reset)
//   enable, wr  request present / 1 = write, 0 = read
//   addr        byte address; word index is addr[ADDR_W-1:1]
//   data_in     write data
//   data_out    read data, zero whenever data_valid = 0
//   data_valid  one-cycle strobe per returned read
//   err         sticky misaligned-access flag, live only when MEM_ERR_CHECK_EN is defined
module multicycle_mem
   import mem_pkg::*;
#(
   parameter int LATENCY = MEM_LATENCY_DEFAULT,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 2**(ADDR_W-1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] data_in,
   output logic [WORD_W-1:0] data_out,
   output logic              data_valid,
   output logic              err
);
   logic [WORD_W-1:0] mem [DEPTH];
   logic [ADDR_W-2:0] idx;
   logic              rd;
   mem_resp_t         issue;
   mem_resp_t         resp;
   assign idx = addr[ADDR_W-1:1];
   assign rd  = enable & ~wr;
   // A write presented during reset is dropped; the array itself is never cleared.
   always_ff @(posedge clk) begin
      if (!rst && enable && wr) mem[idx] <= data_in;
   end
   // Read data is captured at the issue edge, so later writes cannot disturb an in-flight read;
   // bubbles carry zero data so the output never shows stale words.
   assign issue = rd ? '{valid: 1'b1, data: mem[idx]} : '0;
   mem_valid_pipe #(.LATENCY(LATENCY)) u_pipe (
      .clk   (clk),
      .rst   (rst),
      .issue (issue),
      .resp  (resp)
   );
   assign data_valid = resp.valid;
   assign data_out   = resp.data;
`ifdef MEM_ERR_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) err <= 1'b0;
      else if (enable && addr[0]) err <= 1'b1;
   end
`else
   logic unused_addr0;
   assign unused_addr0 = addr[0];
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_mem.sv
// tb_multicycle_mem: table-driven check of multicycle_mem at LATENCY = 4 plus reset and misalignment sequences
module tb_multicycle_mem;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_valid;
   logic        err;
   logic        exp_err;
   int          compared = 0;
   int          mismatched = 0;

   typedef struct {
      logic        en;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] din;
      logic        ev;
      logic [15:0] ed;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   multicycle_mem #(.LATENCY(4), .ADDR_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .wr         (wr),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
      enable  = en;
      wr      = w;
      addr    = a;
      data_in = d;
   endtask

   // Clock one request cycle, then compare the registered outputs just after the edge.
   task automatic step(input string name, input logic ev, input logic [15:0] ed);
      @(posedge clk);
      #1;
      check({name, ".valid"}, {15'd0, data_valid}, {15'd0, ev});
      check({name, ".data"}, data_out, ed);
      check({name, ".err"}, {15'd0, err}, {15'd0, exp_err});
   endtask

   task automatic set_in(input int k, input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
      tbl[k].en   = en;
      tbl[k].wr   = w;
      tbl[k].addr = a;
      tbl[k].din  = d;
   endtask

   task automatic set_exp(input int k, input logic [15:0] d);
      tbl[k].ev = 1'b1;
      tbl[k].ed = d;
   endtask

   initial begin
      // Record k holds the request driven in cycle k and the outputs expected after its closing edge;
      // a read in record k therefore shows up in record k+3.
      for (int k = 0; k < NV; k++) tbl[k] = '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0};
      set_in(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
      set_in(1, 1'b1, 1'b0, 16'h0010, 16'h0);
      set_exp(4, 16'hBEEF);
      for (int j = 0; j < 8; j++) begin
         set_in(2 + j, 1'b1, 1'b1, 16'h0100 + 16'(2 * j), 16'h1000 + 16'(j));
         set_in(10 + j, 1'b1, 1'b0, 16'h0100 + 16'(2 * j), 16'h0);
         set_exp(13 + j, 16'h1000 + 16'(j));
      end
      set_in(18, 1'b1, 1'b1, 16'h0020, 16'h1111);
      set_in(19, 1'b1, 1'b0, 16'h0020, 16'h0);
      set_in(20, 1'b1, 1'b1, 16'h0020, 16'h2222);
      set_in(21, 1'b1, 1'b0, 16'h0020, 16'h0);
      set_exp(22, 16'h1111);
      set_exp(24, 16'h2222);

      exp_err = 1'b0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      step("reset0", 1'b0, 16'h0);
      step("reset1", 1'b0, 16'h0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step("idle", 1'b0, 16'h0);

      for (int k = 0; k < NV; k++) begin
         drive(tbl[k].en, tbl[k].wr, tbl[k].addr, tbl[k].din);
         step($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ed);
      end

      // Three reads in flight, then a one-cycle reset carrying a write that must be dropped.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 16'h0010, 16'h0);
         step("inflight", 1'b0, 16'h0);
      end
      rst = 1'b1;
      drive(1'b1, 1'b1, 16'h0010, 16'hDEAD);
      step("midrst", 1'b0, 16'h0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 8; i++) step("flushed", 1'b0, 16'h0);
      drive(1'b1, 1'b0, 16'h0010, 16'h0);
      step("postrst_rd", 1'b0, 16'h0);
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      step("postrst_w1", 1'b0, 16'h0);
      step("postrst_w2", 1'b0, 16'h0);
      step("postrst_data", 1'b1, 16'hBEEF);

      // Misaligned read returns the enclosing word; err only exists with the check enabled.
      drive(1'b1, 1'b1, 16'h0030, 16'h3030);
      step("wr30", 1'b0, 16'h0);
      drive(1'b1, 1'b0, 16'h0031, 16'h0);
`ifdef MEM_ERR_CHECK_EN
      exp_err = 1'b1;
`endif
      step("rd31", 1'b0, 16'h0);
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      step("rd31_w1", 1'b0, 16'h0);
      step("rd31_w2", 1'b0, 16'h0);
      step("rd31_data", 1'b1, 16'h3030);
      step("err_held", 1'b0, 16'h0);
      rst = 1'b1;
      exp_err = 1'b0;
      step("err_clr", 1'b0, 16'h0);
      rst = 1'b0;
      step("after_clr", 1'b0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/multicycle_mem.md
# multicycle_mem

Word-addressed 16-bit main-memory responder serving the cache fill/write-through interface. Accepts at most one read or write request per cycle and returns each read's data exactly LATENCY cycles later with a one-cycle valid strobe. Reads are fully pipelined, so the cache fill FSM can stream eight consecutive block-word reads back-to-back. Sits below the I-cache and D-cache, behind the memory arbiter.

## Interface

- LATENCY, 4, read latency in cycles; legal range 1..8
- ADDR_W, 16, byte address width; word index is addr[ADDR_W-1:1]
- DEPTH, 2**(ADDR_W-1), number of 16-bit words in the array
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  request present this cycle
- wr  in  1  1 = write, 0 = read; ignored when enable = 0
- addr  in  ADDR_W  byte address of the request
- data_in  in  16  write data
- data_out  out  16  read data; valid only while data_valid = 1
- data_valid  out  1  one-cycle strobe per returned read
- err  out  1  sticky misaligned-access flag (only with MEM_ERR_CHECK_EN)

## Operation

- Request accepted in any cycle with enable = 1; no backpressure, no ready signal.
- Write (enable & wr): array[addr[ADDR_W-1:1]] <= data_in at the edge ending the request cycle. Produces no response and no data_valid.
- Read (enable & ~wr): array word read at the edge ending the request cycle. Data and valid bit enter a LATENCY-stage delay line.
- Capture-at-issue: a read returns the array contents at its issue edge. A write in a later cycle to the same word does not alter in-flight read data.
- Each read produces exactly one data_valid pulse. Reads return strictly in issue order. Idle cycles (enable = 0) propagate as bubbles.
- data_out = 0 whenever data_valid = 0. No stale data is visible.
- rst: clears all delay-line stages, data_valid, data_out and err. Array contents are preserved; memory is not re-initialised. A request presented in the reset cycle is dropped.
- Reset mid-operation: all in-flight reads are discarded and no valid pulse follows.

## Timing

- Read issued in cycle N -> data_valid = 1 and data_out = word in cycle N+LATENCY.
- Back-to-back reads in cycles N..N+7 -> valid in cycles N+LATENCY..N+LATENCY+7, contiguous.
- Write in cycle N is visible to a read issued in cycle N+1 or later.
- Read issued in cycle N+1 returns the data written in cycle N.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset values: data_out = 16'h0000, data_valid = 0, err = 0.

## Configuration

- MEM_ERR_CHECK_EN defined:
  - Any accepted request with addr[0] = 1 sets err (sticky until rst).
  - The request is still executed, using the word index.
- MEM_ERR_CHECK_EN undefined:
  - addr[0] is ignored.
  - err is tied to 0 and has no associated logic.

## Structure

- Package mem_pkg holds:
  - WORD_W = 16
  - MEM_LATENCY_DEFAULT = 4
  - MEM_LATENCY_MAX = 8
  - typedef mem_resp_t {valid, data[15:0]}
- Sub-module mem_valid_pipe: parameterised LATENCY-deep shift register of mem_resp_t with synchronous clear. multicycle_mem instantiates one copy.
- The array lives in multicycle_mem. Optional preload is done via $readmemh in simulation only.

## Test plan

- Reset, then idle 10 cycles -> data_valid = 0, data_out = 0, err = 0 throughout.
- Write 16'hBEEF @ 0x0010 in cycle 5, read 0x0010 in cycle 6 -> data_valid and data_out = 16'hBEEF in cycle 10 (LATENCY = 4).
- Preload words 0x0100..0x010E = 16'h1000..16'h1007; eight back-to-back reads at 0x0100, 0x0102, ..., 0x010E from cycle N -> eight contiguous valid pulses, cycles N+4..N+11, data 16'h1000..16'h1007 in order.
- Read 0x0020 (holds 16'h1111) in cycle N, write 16'h2222 to 0x0020 in cycle N+1 -> cycle N+4 returns 16'h1111; a read issued at N+2 returns 16'h2222 at N+6.
- Three reads in flight, rst asserted at issue+2 for one cycle -> no data_valid pulses afterwards; a subsequent read of a previously written word still returns the written value.
- MEM_ERR_CHECK_EN defined: read at 0x0031 -> err = 1 from the next cycle and held until rst; data returned is word 0x0030. Without the macro, err stays 0.
